// File: rtl/anabellek_hakem_if.sv
// Main-memory iomem bus shared between the arbiter (master) and the memory (slave).
interface anabellek_hakem_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/anabellek_hakem.sv
// Main-memory arbiter: one read-only priority port plus NUM_REQ round-robin requesters,
// grant locked until completion, with a per-transaction timeout and error pulse.
module anabellek_hakem #(
  parameter int          NUM_REQ     = 2,
  parameter logic [7:0]  BASE_HI     = 8'h40,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  anabellek_hakem_if.master       mem,
  input  logic                    prio_valid_i,
  input  logic [31:0]             prio_addr_i,
  output logic                    prio_ready_o,
  output logic [31:0]             prio_rdata_o,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [4*NUM_REQ-1:0]    req_wstrb_i,
  input  logic [17*NUM_REQ-1:0]   req_addr_i,
  input  logic [32*NUM_REQ-1:0]   req_wdata_i,
  output logic [32*NUM_REQ-1:0]   req_rdata_o,
  output logic                    err_o,
  output logic [3:0]              err_id_o
);

  localparam int          IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               grant_prio_r;
  logic [IDX_W-1:0]   grant_idx_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [31:0]        cnt_r;
  logic               err_r;
  logic [3:0]         err_id_r;

  logic               arb_hit_s;
  logic [IDX_W-1:0]   arb_idx_s;
  logic [IDX_W-1:0]   next_rr_s;
  logic               busy_s;
  logic               timeout_s;
  logic               done_s;
  logic [16:0]        sel_addr_s;
  logic [3:0]         sel_wstrb_s;
  logic [31:0]        sel_wdata_s;

  // Round-robin pick: first valid port at or above rr_ptr, otherwise lowest valid port (wrap).
  always_comb begin
    logic             hi_hit_v;
    logic [IDX_W-1:0] hi_idx_v;
    logic [IDX_W-1:0] lo_idx_v;
    hi_hit_v = 1'b0;
    hi_idx_v = {IDX_W{1'b0}};
    lo_idx_v = {IDX_W{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      lo_idx_v = req_valid_i[k] ? IDX_W'(k) : lo_idx_v;
      hi_idx_v = (req_valid_i[k] && (IDX_W'(k) >= rr_ptr_r)) ? IDX_W'(k) : hi_idx_v;
      hi_hit_v = hi_hit_v | (req_valid_i[k] && (IDX_W'(k) >= rr_ptr_r));
    end
    arb_hit_s = |req_valid_i;
    arb_idx_s = hi_hit_v ? hi_idx_v : lo_idx_v;
  end

  assign next_rr_s = (grant_idx_r == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : grant_idx_r + IDX_W'(1);

  // Payload mux of the locked requester, AND-OR form driven by the registered grant only.
  always_comb begin
    sel_addr_s  = 17'h0;
    sel_wstrb_s = 4'h0;
    sel_wdata_s = 32'h0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_addr_s  = sel_addr_s  | ({17{grant_idx_r == IDX_W'(k)}} & req_addr_i[17*k +: 17]);
      sel_wstrb_s = sel_wstrb_s | ({4{grant_idx_r == IDX_W'(k)}}  & req_wstrb_i[4*k +: 4]);
      sel_wdata_s = sel_wdata_s | ({32{grant_idx_r == IDX_W'(k)}} & req_wdata_i[32*k +: 32]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state and per-cycle status; a timeout completes the transaction like a ready.
  always_comb begin
    state_s   = state_r;
    busy_s    = 1'b0;
    timeout_s = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_s = (prio_valid_i || arb_hit_s) ? ST_BUSY : ST_IDLE;
      end
      ST_BUSY: begin
        busy_s    = 1'b1;
        timeout_s = TO_EN && (cnt_r == TO_LAST) && !mem.iomem_ready;
        done_s    = mem.iomem_ready || timeout_s;
        state_s   = done_s ? ST_DONE : ST_BUSY;
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Grant capture, round-robin pointer and wait counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_prio_r <= 1'b0;
      grant_idx_r  <= {IDX_W{1'b0}};
      rr_ptr_r     <= {IDX_W{1'b0}};
      cnt_r        <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          grant_prio_r <= prio_valid_i;
          grant_idx_r  <= arb_idx_s;
          cnt_r        <= 32'd0;
        end
        ST_BUSY: begin
          cnt_r    <= mem.iomem_ready ? cnt_r : cnt_r + 32'd1;
          rr_ptr_r <= (done_s && !grant_prio_r) ? next_rr_s : rr_ptr_r;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Error pulse one cycle after a timeout, with the offending grant index held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r    <= 1'b0;
      err_id_r <= 4'h0;
    end else begin
      err_r    <= timeout_s;
      err_id_r <= timeout_s ? (grant_prio_r ? 4'hF : 4'(grant_idx_r)) : err_id_r;
    end
  end

  assign err_o    = err_r;
  assign err_id_o = err_id_r;

  assign mem.iomem_valid = busy_s & ~timeout_s;
  assign mem.iomem_addr  = !busy_s      ? 32'h0 :
                           grant_prio_r ? prio_addr_i :
                                          {BASE_HI, 5'b00000, sel_addr_s, 2'b00};
  assign mem.iomem_wstrb = (busy_s && !grant_prio_r) ? sel_wstrb_s : 4'h0;
  assign mem.iomem_wdata = (busy_s && !grant_prio_r) ? sel_wdata_s : 32'h0;

  assign prio_ready_o = done_s & grant_prio_r;
  assign prio_rdata_o = (timeout_s && grant_prio_r) ? ERR_DATA : mem.iomem_rdata;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_port
    assign req_ready_o[k]         = done_s & ~grant_prio_r & (grant_idx_r == IDX_W'(k));
    assign req_rdata_o[32*k +: 32] = (timeout_s && !grant_prio_r && (grant_idx_r == IDX_W'(k))) ?
                                     ERR_DATA : mem.iomem_rdata;
  end

endmodule

// File: tb/tb_anabellek_hakem.sv
// Self-checking bench for anabellek_hakem: directed scenarios plus randomized traffic against a transaction-level model.
module tb_anabellek_hakem;

  localparam int          N    = 3;
  localparam int          TO   = 8;
  localparam int          NONE = -2;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic              clk_i        = 1'b0;
  logic              rst_ni       = 1'b0;
  logic              prio_valid_i = 1'b0;
  logic [31:0]       prio_addr_i  = 32'h0;
  logic              prio_ready_o;
  logic [31:0]       prio_rdata_o;
  logic [N-1:0]      req_valid_i  = '0;
  logic [N-1:0]      req_ready_o;
  logic [4*N-1:0]    req_wstrb_i  = '0;
  logic [17*N-1:0]   req_addr_i   = '0;
  logic [32*N-1:0]   req_wdata_i  = '0;
  logic [32*N-1:0]   req_rdata_o;
  logic              err_o;
  logic [3:0]        err_id_o;

  anabellek_hakem_if mem_if ();

  anabellek_hakem #(.NUM_REQ(N), .BASE_HI(8'h40), .TIMEOUT_CYC(TO), .ERR_DATA(ERRD)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mem(mem_if),
    .prio_valid_i(prio_valid_i), .prio_addr_i(prio_addr_i),
    .prio_ready_o(prio_ready_o), .prio_rdata_o(prio_rdata_o),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wstrb_i(req_wstrb_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rdata_o(req_rdata_o),
    .err_o(err_o), .err_id_o(err_id_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // transaction-level model: who owns the bus, bubble, waited cycles, next round-robin start
  int  m_owner    = NONE;
  bit  m_bubble   = 1'b0;
  int  m_wait     = 0;
  int  m_next     = 0;
  bit  m_err_pend = 1'b0;
  int  m_err_id   = 0;
  int  mem_lat    = 1;
  bit  mem_rdy    = 1'b0;
  int  done_src   = NONE;
  bit  keep_valid = 1'b0;
  bit  rnd_mode   = 1'b0;
  bit  use_fixed  = 1'b0;
  logic [31:0] fixed_rdata = 32'h0;

  logic [31:0] cap_addr, cap_wdata, cap_rdata;
  logic [3:0]  cap_wstrb, cap_err_id;
  int          valid_cnt = 0;
  int          err_cnt   = 0;
  bit          prev_valid = 1'b0;
  logic [31:0] grant_log[$];

  function automatic logic [31:0] req_byte_addr(input logic [16:0] w);
    return 32'h4000_0000 + ({15'd0, w} << 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit           busy;
    bit           to;
    bit           e_prdy;
    logic [N-1:0] e_rdy;
    int           j;
    @(negedge clk_i);
    if (done_src != NONE && !keep_valid) begin
      if (done_src == -1) prio_valid_i = 1'b0;
      else req_valid_i[done_src] = 1'b0;
    end
    if (rnd_mode) begin
      for (int k = 0; k < N; k++) begin
        if (!req_valid_i[k] && done_src != k) begin
          req_addr_i[17*k +: 17]  = 17'($urandom);
          req_wstrb_i[4*k +: 4]   = 4'($urandom);
          req_wdata_i[32*k +: 32] = $urandom;
          req_valid_i[k]          = ($urandom_range(0, 3) == 0);
        end
      end
      if (!prio_valid_i && done_src != -1) begin
        prio_addr_i  = $urandom;
        prio_valid_i = ($urandom_range(0, 7) == 0);
      end
    end
    done_src = NONE;
    busy = (m_owner != NONE);
    mem_rdy = busy && (mem_lat != 0) && (m_wait + 1 == mem_lat);
    mem_if.iomem_ready = mem_rdy;
    mem_if.iomem_rdata = use_fixed ? fixed_rdata : $urandom;
    #1;
    to = busy && (m_wait == TO - 1) && !mem_rdy;
    chk("iomem_valid", 32'(mem_if.iomem_valid), 32'(busy && !to));
    if (busy && m_owner == -1) begin
      chk("prio_addr", mem_if.iomem_addr, prio_addr_i);
      chk("prio_wstrb", 32'(mem_if.iomem_wstrb), 32'h0);
    end else if (busy) begin
      chk("req_addr", mem_if.iomem_addr, req_byte_addr(req_addr_i[17*m_owner +: 17]));
      chk("req_wstrb", 32'(mem_if.iomem_wstrb), 32'(req_wstrb_i[4*m_owner +: 4]));
      chk("req_wdata", mem_if.iomem_wdata, req_wdata_i[32*m_owner +: 32]);
    end
    e_rdy  = '0;
    e_prdy = 1'b0;
    if (busy && (mem_rdy || to)) begin
      if (m_owner == -1) e_prdy = 1'b1;
      else e_rdy[m_owner] = 1'b1;
    end
    chk("req_ready", 32'(req_ready_o), 32'(e_rdy));
    chk("prio_ready", 32'(prio_ready_o), 32'(e_prdy));
    for (int k = 0; k < N; k++) begin
      if (!to) chk("req_rdata", req_rdata_o[32*k +: 32], mem_if.iomem_rdata);
      else if (k == m_owner) chk("req_rdata_err", req_rdata_o[32*k +: 32], ERRD);
    end
    if (!to) chk("prio_rdata", prio_rdata_o, mem_if.iomem_rdata);
    else if (m_owner == -1) chk("prio_rdata_err", prio_rdata_o, ERRD);
    chk("err_o", 32'(err_o), 32'(m_err_pend));
    if (m_err_pend) chk("err_id", 32'(err_id_o), 32'(m_err_id));
    // observations used by the directed scenarios
    if (mem_if.iomem_valid === 1'b1) begin
      valid_cnt++;
      cap_addr  = mem_if.iomem_addr;
      cap_wstrb = mem_if.iomem_wstrb;
      cap_wdata = mem_if.iomem_wdata;
      if (!prev_valid) grant_log.push_back(mem_if.iomem_addr);
    end
    prev_valid = (mem_if.iomem_valid === 1'b1);
    if (m_owner >= 0 && req_ready_o[m_owner] === 1'b1) cap_rdata = req_rdata_o[32*m_owner +: 32];
    if (m_owner == -1 && prio_ready_o === 1'b1) cap_rdata = prio_rdata_o;
    if (err_o === 1'b1) begin
      err_cnt++;
      cap_err_id = err_id_o;
    end
    @(posedge clk_i);
    m_err_pend = 1'b0;
    if (busy) begin
      if (mem_rdy || to) begin
        if (m_owner >= 0) m_next = (m_owner + 1) % N;
        m_err_pend = to;
        m_err_id   = (m_owner < 0) ? 15 : m_owner;
        done_src   = m_owner;
        m_owner    = NONE;
        m_bubble   = 1'b1;
      end else begin
        m_wait++;
      end
    end else if (m_bubble) begin
      m_bubble = 1'b0;
    end else begin
      if (prio_valid_i) m_owner = -1;
      for (int i = 0; i < N; i++) begin
        j = (m_next + i) % N;
        if (m_owner == NONE && req_valid_i[j]) m_owner = j;
      end
      if (m_owner != NONE) begin
        m_wait = 0;
        if (rnd_mode) mem_lat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      end
    end
    #1;
  endtask

  initial begin
    mem_if.iomem_ready = 1'b0;
    mem_if.iomem_rdata = 32'h0;

    // reset with idle bus
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", 32'(mem_if.iomem_valid), 32'h0);
    chk("rst_req_ready", 32'(req_ready_o), 32'h0);
    chk("rst_prio_ready", 32'(prio_ready_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_err_id", 32'(err_id_o), 32'h0);
    rst_ni = 1'b1;
    repeat (3) cycle();

    // single read on requester 0, memory ready on the second BUSY cycle
    req_addr_i[16:0] = 17'h00010;
    req_wstrb_i[3:0] = 4'h0;
    req_valid_i[0]   = 1'b1;
    mem_lat     = 2;
    use_fixed   = 1'b1;
    fixed_rdata = 32'h12345678;
    valid_cnt   = 0;
    repeat (5) cycle();
    use_fixed = 1'b0;
    chk("read_addr", cap_addr, 32'h40000040);
    chk("read_valid_cycles", 32'(valid_cnt), 32'd2);
    chk("read_rdata", cap_rdata, 32'h12345678);

    // write from requester 1 at the top word address
    req_addr_i[33:17]  = 17'h1FFFF;
    req_wstrb_i[7:4]   = 4'b0011;
    req_wdata_i[63:32] = 32'hCAFEBABE;
    req_valid_i[1]     = 1'b1;
    mem_lat = 1;
    repeat (4) cycle();
    chk("write_addr", cap_addr, 32'h4007FFFC);
    chk("write_wstrb", 32'(cap_wstrb), 32'h3);
    chk("write_wdata", cap_wdata, 32'hCAFEBABE);

    // priority arrives while requester 1 holds the bus; req0 waits behind it
    grant_log.delete();
    req_addr_i[33:17] = 17'h00002;
    req_wstrb_i[7:4]  = 4'h0;
    req_valid_i[1]    = 1'b1;
    mem_lat = 3;
    cycle();
    prio_addr_i      = 32'h20000004;
    prio_valid_i     = 1'b1;
    req_addr_i[16:0] = 17'h00005;
    req_valid_i[0]   = 1'b1;
    repeat (16) cycle();
    chk("lock_grants", 32'(grant_log.size()), 32'd3);
    chk("lock_first", (grant_log.size() > 0) ? grant_log[0] : 32'hX, 32'h40000008);
    chk("lock_prio", (grant_log.size() > 1) ? grant_log[1] : 32'hX, 32'h20000004);
    chk("lock_req0", (grant_log.size() > 2) ? grant_log[2] : 32'hX, 32'h40000014);

    // timeout: memory never answers
    err_cnt   = 0;
    cap_rdata = 32'h0;
    req_addr_i[16:0] = 17'h00100;
    req_valid_i[0]   = 1'b1;
    mem_lat = 0;
    repeat (11) cycle();
    chk("to_rdata", cap_rdata, ERRD);
    chk("to_err_pulses", 32'(err_cnt), 32'd1);
    chk("to_err_id", 32'(cap_err_id), 32'h0);

    // reset pulled in the middle of a BUSY transaction
    err_cnt        = 0;
    req_valid_i[0] = 1'b1;
    mem_lat = 0;
    repeat (3) cycle();
    #2 rst_ni = 1'b0;
    #1;
    chk("abort_valid", 32'(mem_if.iomem_valid), 32'h0);
    chk("abort_ready", 32'(req_ready_o), 32'h0);
    chk("abort_err", 32'(err_o), 32'h0);
    req_valid_i = '0;
    m_owner = NONE; m_bubble = 1'b0; m_next = 0; m_err_pend = 1'b0; done_src = NONE;
    prev_valid = 1'b0;
    #1 rst_ni = 1'b1;
    repeat (4) cycle();
    chk("abort_no_err", 32'(err_cnt), 32'd0);

    // fairness: all requesters valid continuously, one-cycle memory
    grant_log.delete();
    keep_valid = 1'b1;
    for (int k = 0; k < N; k++) begin
      req_addr_i[17*k +: 17] = 17'(k + 1);
      req_wstrb_i[4*k +: 4]  = 4'h0;
    end
    req_valid_i = '1;
    mem_lat = 1;
    repeat (18) cycle();
    req_valid_i = '0;
    keep_valid  = 1'b0;
    chk("fair_grants", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      chk("fair_order", (i < grant_log.size()) ? grant_log[i] : 32'hX,
          32'h40000000 + 32'(((i % N) + 1) * 4));
    repeat (2) cycle();

    // randomized traffic against the model
    rnd_mode = 1'b1;
    repeat (500) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
